// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
//   pc_state_e  : sequencing state (running / halted)
//   int_cmd_e   : {int_disable_cmd, int_enable_cmd} command codes
//   word_offset : sign-extend a word immediate and scale it to a byte offset
package pc_seq_pkg;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } pc_state_e;

  localparam logic [15:0] IntVectorDefault = 16'h0004;

  typedef enum logic [1:0] {
    IntCmdNone    = 2'b00,
    IntCmdEnable  = 2'b01,
    IntCmdDisable = 2'b10,
    IntCmdBoth    = 2'b11
  } int_cmd_e;

  // imm holds an imm_w-bit signed word offset in its low bits (upper bits zero).
  // Returns the sign-extended offset shifted left by one (byte offset).
  function automatic logic [31:0] word_offset(input logic [31:0] imm,
                                              input int unsigned imm_w);
    logic signed [31:0] tmp;
    tmp = $signed(imm << (32 - imm_w));
    tmp = tmp >>> (32 - imm_w);
    return {tmp[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack with combinational top-of-stack read.
//   clk_i/rst_ni   : clock, async active-low reset
//   clear_i        : synchronous clear (empties the stack)
//   push_i/pop_i   : push wins if both asserted
//   wr_data_i      : value to push
//   rd_data_o      : current top of stack
//   count_o        : number of valid entries (0..RAS_DEPTH)
//   empty_o/full_o : occupancy status
//   overflow_o     : pulse, push while full (oldest entry overwritten)
//   underflow_o    : pulse, pop while empty (ignored)
module return_address_stack #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [ADDR_W-1:0]                wr_data_i,
  output logic [ADDR_W-1:0]                rd_data_o,
  output logic [$clog2(RAS_DEPTH):0]       count_o,
  output logic                             empty_o,
  output logic                             full_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CntW-1:0]   count_q, count_d;

  // Power-of-two depth: pointer arithmetic wraps, giving the circular overwrite.
  assign top_ptr     = wr_ptr_q - PtrW'(1);
  assign rd_data_o   = mem_q[top_ptr];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CntW'(RAS_DEPTH));
  assign overflow_o  = push_i & full_o;
  assign underflow_o = pop_i & ~push_i & empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (!full_o) count_d = count_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential fetch, branches, jumps, jump-and-link,
// RETURN through a return-address stack, and single-level interrupt entry/exit.
//   clk_i, rst_ni              : clock, async active-low reset
//   clk_en_i                   : advance enable (everything holds when low)
//   soft_reset_i ... irq_i     : decoded instruction flags and interrupt request
//   pc_o                       : current fetch address
//   int_enabled_o, in_isr_o    : interrupt status
//   int_ack_o                  : one-cycle pulse on ISR entry
//   ras_*_o                    : return-address stack status and sticky errors
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 16,
  parameter int unsigned        BR_IMM_W   = 6,
  parameter int unsigned        J_IMM_W    = 12,
  parameter int unsigned        RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]  INT_VECTOR = ADDR_W'(IntVectorDefault)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clk_en_i,
  input  logic                soft_reset_i,
  input  logic                halt_cmd_i,
  input  logic                branch_taken_i,
  input  logic [BR_IMM_W-1:0] branch_immediate_i,
  input  logic                jump_taken_i,
  input  logic                jump_link_i,
  input  logic [J_IMM_W-1:0]  jump_immediate_i,
  input  logic                return_cmd_i,
  input  logic                int_enable_cmd_i,
  input  logic                int_disable_cmd_i,
  input  logic                int_trigger_cmd_i,
  input  logic                irq_i,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                int_enabled_o,
  output logic                in_isr_o,
  output logic                int_ack_o,
  output logic                ras_empty_o,
  output logic                ras_full_o,
  output logic                ras_overflow_o,
  output logic                ras_underflow_o
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [CntW-1:0]   isr_base_q, isr_base_d;
  logic              in_isr_q, in_isr_d, int_en_q, int_en_d, int_ack_q, int_ack_d;
  logic              ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;

  logic [ADDR_W-1:0] seq_pc, br_off, j_off, ras_top;
  logic [CntW-1:0]   ras_count;
  logic              ras_push, ras_pop, ras_clear, ras_empty, ras_full;
  logic              ras_ovf_pulse, ras_unf_pulse, int_req;
  int_cmd_e          int_cmd;

  assign seq_pc  = pc_q + ADDR_W'(2);
  assign br_off  = ADDR_W'(word_offset(32'(branch_immediate_i), BR_IMM_W));
  assign j_off   = ADDR_W'(word_offset(32'(jump_immediate_i), J_IMM_W));
  assign int_req = (irq_i | int_trigger_cmd_i) & int_en_q & ~in_isr_q;
  assign int_cmd = int_cmd_e'({int_disable_cmd_i, int_enable_cmd_i});

  return_address_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (ras_clear),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .wr_data_i  (seq_pc),
    .rd_data_o  (ras_top),
    .count_o    (ras_count),
    .empty_o    (ras_empty),
    .full_o     (ras_full),
    .overflow_o (ras_ovf_pulse),
    .underflow_o(ras_unf_pulse)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      pc_q       <= '0;
      epc_q      <= '0;
      isr_base_q <= '0;
      in_isr_q   <= 1'b0;
      int_en_q   <= 1'b0;
      int_ack_q  <= 1'b0;
      ras_ovf_q  <= 1'b0;
      ras_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      isr_base_q <= isr_base_d;
      in_isr_q   <= in_isr_d;
      int_en_q   <= int_en_d;
      int_ack_q  <= int_ack_d;
      ras_ovf_q  <= ras_ovf_d;
      ras_unf_q  <= ras_unf_d;
    end
  end

  // Next-state logic, in decreasing priority.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    isr_base_d = isr_base_q;
    in_isr_d   = in_isr_q;
    int_en_d   = int_en_q;
    int_ack_d  = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_clear  = 1'b0;

    if (clk_en_i) begin
      if (soft_reset_i) begin
        state_d    = StRun;
        pc_d       = '0;
        epc_d      = '0;
        isr_base_d = '0;
        in_isr_d   = 1'b0;
        int_en_d   = 1'b0;
        ras_clear  = 1'b1;
      end else begin
        unique case (int_cmd)
          IntCmdEnable:              int_en_d = 1'b1;
          IntCmdDisable, IntCmdBoth: int_en_d = 1'b0;
          default:                   ;
        endcase

        if (int_req) begin
          // pc + 2 is the resume address whether running or halted.
          epc_d      = seq_pc;
          isr_base_d = ras_count;
          pc_d       = INT_VECTOR;
          in_isr_d   = 1'b1;
          int_en_d   = 1'b0;
          int_ack_d  = 1'b1;
          state_d    = StRun;
        end else if (halt_cmd_i) begin
          state_d = StHalted;
        end else if (state_q == StHalted) begin
          pc_d = pc_q;
        end else if (return_cmd_i) begin
          if (in_isr_q && (ras_count == isr_base_q)) begin
            pc_d     = epc_q;
            in_isr_d = 1'b0;
            int_en_d = 1'b1;
          end else begin
            ras_pop = 1'b1;
            pc_d    = ras_empty ? seq_pc : ras_top;
          end
        end else if (jump_link_i) begin
          ras_push = 1'b1;
          pc_d     = seq_pc + j_off;
          // Overwrite drops the oldest entry, which sits below the ISR frame.
          if (in_isr_q && ras_full && (isr_base_q != '0)) begin
            isr_base_d = isr_base_q - CntW'(1);
          end
        end else if (jump_taken_i) begin
          pc_d = seq_pc + j_off;
        end else if (branch_taken_i) begin
          pc_d = seq_pc + br_off;
        end else begin
          pc_d = seq_pc;
        end
      end
    end
  end

  // Sticky stack error flags.
  always_comb begin
    ras_ovf_d = ras_ovf_q | ras_ovf_pulse;
    ras_unf_d = ras_unf_q | ras_unf_pulse;
    if (clk_en_i && soft_reset_i) begin
      ras_ovf_d = 1'b0;
      ras_unf_d = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    pc_o            = pc_q;
    int_enabled_o   = int_en_q;
    in_isr_o        = in_isr_q;
    int_ack_o       = int_ack_q;
    ras_empty_o     = ras_empty;
    ras_full_o      = ras_full;
    ras_overflow_o  = ras_ovf_q;
    ras_underflow_o = ras_unf_q;
  end

endmodule
